// File: rtl/store_buffer_if.sv
// L2 request (pci) and L2 response (cpi) bundle for the store buffer.
// master = store buffer side, slave = L2 side.
interface store_buffer_if;
    logic         pci_valid_o;
    logic         pci_ack_i;
    logic [1:0]   pci_unit_o;
    logic [1:0]   pci_strand_o;
    logic [2:0]   pci_op_o;
    logic [1:0]   pci_way_o;
    logic [25:0]  pci_address_o;
    logic [511:0] pci_data_o;
    logic [63:0]  pci_mask_o;
    logic         cpi_valid_i;
    logic [1:0]   cpi_unit_i;
    logic [1:0]   cpi_strand_i;
    logic [1:0]   cpi_op_i;
    logic         cpi_update_i;

    modport master (
        output pci_valid_o, pci_unit_o, pci_strand_o, pci_op_o,
        output pci_way_o, pci_address_o, pci_data_o, pci_mask_o,
        input  pci_ack_i,
        input  cpi_valid_i, cpi_unit_i, cpi_strand_i, cpi_op_i,
        input  cpi_update_i
    );

    modport slave (
        input  pci_valid_o, pci_unit_o, pci_strand_o, pci_op_o,
        input  pci_way_o, pci_address_o, pci_data_o, pci_mask_o,
        output pci_ack_i,
        output cpi_valid_i, cpi_unit_i, cpi_strand_i, cpi_op_i,
        output cpi_update_i
    );
endinterface

// File: rtl/store_buffer.sv
// Per-strand pending-store queue: captures stores, issues them to L2,
// retires them on store acks and forwards pending data to own-strand loads.
module store_buffer #(
    parameter logic [1:0] UNIT_ID     = 2'd2,
    parameter int         NUM_STRANDS = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          store_i,
    input  logic          access_i,
    input  logic [1:0]    strand_i,
    input  logic [25:0]   address_i,
    input  logic [511:0]  data_i,
    input  logic [63:0]   mask_i,
    output logic          rollback_o,
    output logic [3:0]    store_resume_strands_o,
    output logic [511:0]  data_o,
    output logic [63:0]   mask_o,
    output logic          store_update_o,
    output logic [4:0]    store_update_set_o,
    store_buffer_if.master bus
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        ISSUED  = 2'd2
    } state_e;

    state_e       state_q [NUM_STRANDS];
    state_e       state_d [NUM_STRANDS];
    logic [25:0]  addr_q  [NUM_STRANDS];
    logic [511:0] data_q  [NUM_STRANDS];
    logic [63:0]  mask_q  [NUM_STRANDS];

    logic [1:0]   ptr_q, ptr_d;
    logic [1:0]   sel_q, sel_d;
    logic         req_q, req_d;
    logic         rollback_q, rollback_d;
    logic [3:0]   resume_q, resume_d;
    logic [511:0] fwd_data_q, fwd_data_d;
    logic [63:0]  fwd_mask_q, fwd_mask_d;

    logic         capture;
    logic         resp_match;
    logic         fwd_hit;
    logic         found;
    logic [1:0]   pick;
    logic [1:0]   idx;

    assign capture    = store_i && (state_q[strand_i] == EMPTY);
    assign resp_match = bus.cpi_valid_i && (bus.cpi_unit_i == UNIT_ID)
                     && (bus.cpi_op_i == 2'd1)
                     && (state_q[bus.cpi_strand_i] == ISSUED);
    assign fwd_hit    = (state_q[strand_i] != EMPTY)
                     && (addr_q[strand_i] == address_i);

    // Round-robin search for the first PENDING entry at or after ptr_q.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = '0;
        for (int k = 0; k < NUM_STRANDS; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && state_q[idx] == PENDING) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next-state: capture/reject, L2 issue handshake, ack retire, forwarding.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        req_d      = req_q;
        rollback_d = 1'b0;
        resume_d   = '0;
        fwd_data_d = fwd_data_q;
        fwd_mask_d = '0;

        if (store_i) begin
            rollback_d = !capture;
        end
        if (capture) begin
            state_d[strand_i] = PENDING;
        end

        if (req_q) begin
            if (bus.pci_ack_i) begin
                state_d[sel_q] = ISSUED;
                req_d          = 1'b0;
                ptr_d          = sel_q + 2'd1;
            end
        end else if (found) begin
            req_d = 1'b1;
            sel_d = pick;
        end

        if (resp_match) begin
            state_d[bus.cpi_strand_i]  = EMPTY;
            resume_d[bus.cpi_strand_i] = 1'b1;
        end

        if (access_i) begin
            fwd_data_d = data_q[strand_i];
            if (fwd_hit) begin
                fwd_mask_d = mask_q[strand_i];
            end
        end
    end

    // State registers with synchronous reset; entry payload loads on capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STRANDS; i++) begin
                state_q[i] <= EMPTY;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                mask_q[i]  <= '0;
            end
            ptr_q      <= '0;
            sel_q      <= '0;
            req_q      <= 1'b0;
            rollback_q <= 1'b0;
            resume_q   <= '0;
            fwd_data_q <= '0;
            fwd_mask_q <= '0;
        end else begin
            for (int i = 0; i < NUM_STRANDS; i++) begin
                state_q[i] <= state_d[i];
            end
            if (capture) begin
                addr_q[strand_i] <= address_i;
                data_q[strand_i] <= data_i;
                mask_q[strand_i] <= mask_i;
            end
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            req_q      <= req_d;
            rollback_q <= rollback_d;
            resume_q   <= resume_d;
            fwd_data_q <= fwd_data_d;
            fwd_mask_q <= fwd_mask_d;
        end
    end

    assign rollback_o             = rollback_q;
    assign store_resume_strands_o = resume_q;
    assign data_o                 = fwd_data_q;
    assign mask_o                 = fwd_mask_q;
    assign store_update_o         = resp_match && bus.cpi_update_i;
    assign store_update_set_o     = addr_q[bus.cpi_strand_i][4:0];

    assign bus.pci_valid_o   = req_q;
    assign bus.pci_unit_o    = req_q ? UNIT_ID : 2'd0;
    assign bus.pci_strand_o  = sel_q;
    assign bus.pci_op_o      = req_q ? 3'd1 : 3'd0;
    assign bus.pci_way_o     = 2'd0;
    assign bus.pci_address_o = addr_q[sel_q];
    assign bus.pci_data_o    = data_q[sel_q];
    assign bus.pci_mask_o    = mask_q[sel_q];

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: issue handshake,
// ack retire, rollback, round-robin order, forwarding and reset.
module tb_store_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         store_i;
    logic         access_i;
    logic [1:0]   strand_i;
    logic [25:0]  address_i;
    logic [511:0] data_i;
    logic [63:0]  mask_i;
    logic         rollback_o;
    logic [3:0]   store_resume_strands_o;
    logic [511:0] data_o;
    logic [63:0]  mask_o;
    logic         store_update_o;
    logic [4:0]   store_update_set_o;

    store_buffer_if bus ();

    store_buffer dut (
        .clk                    (clk),
        .reset                  (reset),
        .store_i                (store_i),
        .access_i               (access_i),
        .strand_i               (strand_i),
        .address_i              (address_i),
        .data_i                 (data_i),
        .mask_i                 (mask_i),
        .rollback_o             (rollback_o),
        .store_resume_strands_o (store_resume_strands_o),
        .data_o                 (data_o),
        .mask_o                 (mask_o),
        .store_update_o         (store_update_o),
        .store_update_set_o     (store_update_set_o),
        .bus                    (bus)
    );

    always #5 clk = ~clk;

    localparam logic [511:0] D1 = {16{32'hA5A5_0001}};
    localparam logic [511:0] D2 = {16{32'h1234_5678}};
    localparam logic [511:0] D3 = {16{32'hDEAD_BEEF}};
    localparam logic [511:0] D4 = {16{32'h0F0F_7777}};
    localparam logic [511:0] D5 = {16{32'hCAFE_0005}};

    int checks   = 0;
    int failures = 0;

    logic [25:0]  exp_addr [4];
    logic [511:0] exp_data [4];
    logic [63:0]  exp_mask [4];

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [1:0] s, input logic [25:0] a,
                            input logic [511:0] d, input logic [63:0] m);
        store_i   = 1'b1;
        strand_i  = s;
        address_i = a;
        data_i    = d;
        mask_i    = m;
        exp_addr[s] = a;
        exp_data[s] = d;
        exp_mask[s] = m;
        tick();
        store_i = 1'b0;
    endtask

    task automatic lookup(input logic [1:0] s, input logic [25:0] a);
        access_i  = 1'b1;
        strand_i  = s;
        address_i = a;
        tick();
        access_i = 1'b0;
    endtask

    // Wait (bounded) for a request, check it targets strand s, then ack it.
    task automatic wait_issue(input logic [1:0] s);
        int n;
        n = 0;
        while (!bus.pci_valid_o && n < 10) begin
            tick();
            n++;
        end
        chk("issue_valid", 512'(bus.pci_valid_o), 512'(1));
        chk("issue_strand", 512'(bus.pci_strand_o), 512'(s));
        chk("issue_addr", 512'(bus.pci_address_o), 512'(exp_addr[s]));
        chk("issue_data", bus.pci_data_o, exp_data[s]);
        chk("issue_mask", 512'(bus.pci_mask_o), 512'(exp_mask[s]));
        chk("issue_op", 512'(bus.pci_op_o), 512'(3'd1));
        chk("issue_unit", 512'(bus.pci_unit_o), 512'(2'd2));
        chk("issue_way", 512'(bus.pci_way_o), 512'(2'd0));
        bus.pci_ack_i = 1'b1;
        tick();
        bus.pci_ack_i = 1'b0;
        chk("issue_drop", 512'(bus.pci_valid_o), 512'(0));
    endtask

    task automatic drive_resp(input logic [1:0] u, input logic [1:0] s,
                              input logic upd);
        bus.cpi_valid_i  = 1'b1;
        bus.cpi_unit_i   = u;
        bus.cpi_strand_i = s;
        bus.cpi_op_i     = 2'd1;
        bus.cpi_update_i = upd;
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        store_i   = 1'b0;
        access_i  = 1'b0;
        strand_i  = '0;
        address_i = '0;
        data_i    = '0;
        mask_i    = '0;
        bus.pci_ack_i    = 1'b0;
        bus.cpi_valid_i  = 1'b0;
        bus.cpi_unit_i   = '0;
        bus.cpi_strand_i = '0;
        bus.cpi_op_i     = '0;
        bus.cpi_update_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_addr[i] = '0;
            exp_data[i] = '0;
            exp_mask[i] = '0;
        end

        tick();
        tick();
        chk("rst_valid", 512'(bus.pci_valid_o), 512'(0));
        chk("rst_rollback", 512'(rollback_o), 512'(0));
        chk("rst_resume", 512'(store_resume_strands_o), 512'(0));
        chk("rst_mask", 512'(mask_o), 512'(0));
        chk("rst_update", 512'(store_update_o), 512'(0));
        reset = 1'b0;
        tick();

        do_store(2'd2, 26'h1234, D1, 64'hF);
        chk("s2_rollback", 512'(rollback_o), 512'(0));
        chk("s2_valid_early", 512'(bus.pci_valid_o), 512'(0));
        tick();
        chk("s2_valid", 512'(bus.pci_valid_o), 512'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s2_hold_valid", 512'(bus.pci_valid_o), 512'(1));
            chk("s2_hold_addr", 512'(bus.pci_address_o), 512'(26'h1234));
        end
        wait_issue(2'd2);
        tick();
        chk("s2_no_reissue", 512'(bus.pci_valid_o), 512'(0));

        do_store(2'd2, 26'h5555, D3, 64'h1);
        chk("busy_rollback", 512'(rollback_o), 512'(1));
        tick();
        chk("rollback_pulse", 512'(rollback_o), 512'(0));
        lookup(2'd2, 26'h1234);
        chk("busy_keep_mask", 512'(mask_o), 512'(64'hF));
        chk("busy_keep_data", data_o, D1);

        drive_resp(2'd2, 2'd2, 1'b1);
        chk("resp_update", 512'(store_update_o), 512'(1));
        chk("resp_set", 512'(store_update_set_o), 512'(5'h14));
        tick();
        bus.cpi_valid_i = 1'b0;
        chk("resp_resume", 512'(store_resume_strands_o), 512'(4'b0100));
        tick();
        chk("resume_pulse", 512'(store_resume_strands_o), 512'(0));
        drive_resp(2'd2, 2'd2, 1'b1);
        chk("repeat_update", 512'(store_update_o), 512'(0));
        tick();
        bus.cpi_valid_i = 1'b0;
        chk("repeat_resume", 512'(store_resume_strands_o), 512'(0));

        do_store(2'd0, 26'h100, D3, 64'hFFFF_0000_0000_0000);
        do_store(2'd1, 26'h40, D2, 64'hFF00);
        chk("s1_rollback", 512'(rollback_o), 512'(0));
        do_store(2'd3, 26'h3FF, D4, 64'h0F);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 512'(bus.pci_valid_o), 512'(1));
            chk("hold_strand", 512'(bus.pci_strand_o), 512'(0));
            chk("hold_addr", 512'(bus.pci_address_o), 512'(26'h100));
            tick();
        end
        lookup(2'd1, 26'h40);
        chk("fwd_hit_mask", 512'(mask_o), 512'(64'hFF00));
        chk("fwd_hit_data", data_o, D2);
        lookup(2'd0, 26'h40);
        chk("fwd_other_strand", 512'(mask_o), 512'(0));

        wait_issue(2'd0);
        drive_resp(2'd2, 2'd0, 1'b0);
        chk("s0_no_l1_update", 512'(store_update_o), 512'(0));
        tick();
        bus.cpi_valid_i = 1'b0;
        chk("s0_resume", 512'(store_resume_strands_o), 512'(4'b0001));
        do_store(2'd0, 26'h2A0, D5, 64'h3);
        chk("s0b_rollback", 512'(rollback_o), 512'(0));
        wait_issue(2'd1);
        wait_issue(2'd3);
        wait_issue(2'd0);

        drive_resp(2'd1, 2'd1, 1'b1);
        chk("bad_unit_update", 512'(store_update_o), 512'(0));
        tick();
        bus.cpi_valid_i = 1'b0;
        chk("bad_unit_resume", 512'(store_resume_strands_o), 512'(0));

        drive_resp(2'd2, 2'd1, 1'b1);
        store_i   = 1'b1;
        strand_i  = 2'd1;
        address_i = 26'h99;
        chk("s1_update", 512'(store_update_o), 512'(1));
        chk("s1_set", 512'(store_update_set_o), 512'(5'h00));
        tick();
        store_i = 1'b0;
        bus.cpi_valid_i = 1'b0;
        chk("free_same_cycle_rb", 512'(rollback_o), 512'(1));
        chk("s1_resume", 512'(store_resume_strands_o), 512'(4'b0010));

        store_i   = 1'b1;
        access_i  = 1'b1;
        strand_i  = 2'd2;
        address_i = 26'h77;
        data_i    = D1;
        mask_i    = 64'h80;
        exp_addr[2] = 26'h77;
        exp_data[2] = D1;
        exp_mask[2] = 64'h80;
        tick();
        store_i  = 1'b0;
        access_i = 1'b0;
        chk("same_cycle_fwd", 512'(mask_o), 512'(0));
        chk("same_cycle_rb", 512'(rollback_o), 512'(0));
        wait_issue(2'd2);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive_resp(2'd2, 2'd2, 1'b1);
        chk("post_rst_update", 512'(store_update_o), 512'(0));
        tick();
        bus.cpi_valid_i = 1'b0;
        chk("post_rst_resume", 512'(store_resume_strands_o), 512'(0));
        chk("post_rst_valid", 512'(bus.pci_valid_o), 512'(0));
        tick();
        chk("post_rst_idle", 512'(bus.pci_valid_o), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
